pll_reset_sequencer: RTL and testbench

//  Sequences start-up and recovery of the system clock domain driven by the 25 MHz PLL output.

---
 rtl/pll_reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: start-up and recovery sequencing for the PLL clock domain.
// Qualifies a synchronised lock flag, holds the core in reset for a fixed period,
// releases it, and returns to reset on lock loss or on an accepted soft-reset request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | core in reset, waiting for synchronised lock
// STABLE    | lock seen, counting LOCK_CYCLES consecutive locked cycles
// HOLD      | lock qualified (or soft reset), core reset held RESET_CYCLES
// RUN       | core released, sys_rst_n=1 and ready=1
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int RESET_CYCLES = 16,
  parameter int LOSS_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              soft_rst_req,
  output logic              soft_rst_ack,
  output logic              sys_rst_n,
  output logic              ready,
  output logic [LOSS_W-1:0] lock_loss_cnt,
  output logic [1:0]        state
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > RESET_CYCLES) ? LOCK_CYCLES : RESET_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0]     LOCK_LAST  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0]     RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              lock_meta;
  logic              lock_s;
  logic              loss_inc;
  logic              ack_nxt;
  logic              run_nxt;
  logic [LOSS_W-1:0] loss_nxt;

  assign state = state_q;

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // State register and phase counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt     <= '0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state logic; lock loss takes priority over a soft-reset request in RUN
  always_comb begin
    state_nxt = state_q;
    loss_inc  = 1'b0;
    ack_nxt   = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s)                state_nxt = WAIT_LOCK;
        else if (cnt == LOCK_LAST)  state_nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_inc  = 1'b1;
        end else if (cnt == RESET_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_inc  = 1'b1;
        end else if (soft_rst_req) begin
          state_nxt = HOLD;
          ack_nxt   = 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase

    if (state_nxt != state_q)
      cnt_nxt = '0;
    else if (state_q == STABLE || state_q == HOLD)
      cnt_nxt = cnt + CW'(1);
    else
      cnt_nxt = '0;
  end

  // Output next values: run flags track the next state so they change with it
  always_comb begin
    run_nxt  = (state_nxt == RUN);
    loss_nxt = lock_loss_cnt;
    if (loss_inc && (lock_loss_cnt != LOSS_MAX))
      loss_nxt = lock_loss_cnt + LOSS_W'(1);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      soft_rst_ack  <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sys_rst_n     <= run_nxt;
      ready         <= run_nxt;
      soft_rst_ack  <= ack_nxt;
      lock_loss_cnt <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with LOCK_CYCLES=8, RESET_CYCLES=4, LOSS_W=2.
// Each driven cycle pushes the expected post-edge outputs; a monitor pops and compares.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       soft_rst_req;
  logic       soft_rst_ack;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] lock_loss_cnt;
  logic [1:0] state;

  typedef struct packed {
    logic [1:0] st;
    logic       srn;
    logic       ack;
    logic [1:0] loss;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [1:0] loss_e;

  pll_reset_sequencer #(
    .LOCK_CYCLES (8),
    .RESET_CYCLES(4),
    .LOSS_W      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
  endtask

  // Compare DUT outputs shortly after each edge against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state",         int'(state),         int'(mon_e.st));
      check("sys_rst_n",     int'(sys_rst_n),     int'(mon_e.srn));
      check("ready",         int'(ready),         int'(mon_e.srn));
      check("soft_rst_ack",  int'(soft_rst_ack),  int'(mon_e.ack));
      check("lock_loss_cnt", int'(lock_loss_cnt), int'(mon_e.loss));
    end
  end

  // Drive inputs for one edge and push the outputs expected after it
  task automatic cyc(input logic rn, input logic lk, input logic rq,
                     input logic [1:0] st, input logic srn, input logic ack,
                     input logic [1:0] loss);
    exp_t e;
    rst_n        = rn;
    locked       = lk;
    soft_rst_req = rq;
    e.st   = st;
    e.srn  = srn;
    e.ack  = ack;
    e.loss = loss;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cycles(input int n, input logic lk, input logic rq,
                        input logic [1:0] st, input logic srn, input logic ack,
                        input logic [1:0] loss);
    for (int i = 0; i < n; i++) cyc(1'b1, lk, rq, st, srn, ack, loss);
  endtask

  // Lock held high from WAIT_LOCK: 2 sync cycles, 8 STABLE, 4 HOLD, then RUN
  task automatic relock(input logic [1:0] loss);
    cycles(2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, loss);
    cycles(8, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, loss);
    cycles(4, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, loss);
    cycles(1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, loss);
  endtask

  // Lock dropped in RUN: two edges still RUN, then WAIT_LOCK with the counter bumped
  task automatic drop_in_run(input logic [1:0] loss_before, input logic [1:0] loss_after);
    cycles(2, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, loss_before);
    cycles(3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, loss_after);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    locked       = 1'b0;
    soft_rst_req = 1'b0;
    loss_e       = 2'd0;
    @(negedge clk);

    // Reset with lock already high, then start-up to RUN on the 15th edge
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    relock(loss_e);

    // Lock loss in RUN, counter to 1, relock
    drop_in_run(loss_e, 2'd1);
    loss_e = 2'd1;
    relock(loss_e);

    // Soft reset: ack, HOLD 4 cycles ignoring the held request, second ack in RUN
    cycles(1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, loss_e);
    cycles(3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, loss_e);
    cycles(1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, loss_e);
    cycles(1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, loss_e);
    cycles(3, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, loss_e);
    cycles(1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, loss_e);

    // Lock loss and soft request on the same edge: loss wins, no ack
    cycles(2, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, loss_e);
    loss_e = 2'd2;
    cycles(3, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, loss_e);

    // Lock glitch during STABLE at cnt=5: back to WAIT_LOCK, no count, full restart
    cycles(2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, loss_e);
    cycles(4, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, loss_e);
    cycles(2, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, loss_e);
    relock(loss_e);

    // Five more drops in RUN: counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      if (loss_e != 2'd3) begin
        drop_in_run(loss_e, loss_e + 2'd1);
        loss_e = loss_e + 2'd1;
      end else begin
        drop_in_run(loss_e, loss_e);
      end
      relock(loss_e);
    end

    // Drop once more, requalify, then rst_n pulse mid-HOLD clears everything
    drop_in_run(loss_e, loss_e);
    cycles(2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, loss_e);
    cycles(8, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, loss_e);
    cycles(2, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, loss_e);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    loss_e = 2'd0;
    relock(loss_e);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
